// File: rtl/opb_reg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : opb_reg_pkg
// Purpose  : Shared OPB register-slave definitions (word offsets, FSM state
//            type, byte-enable merge and bus bit-order helpers).
// Revision : 1.0
// ============================================================================
package opb_reg_pkg;

  // Word index within the 256-byte window (OPB_ABus[24:29])
  localparam logic [5:0] DATA_OFS   = 6'h00;
  localparam logic [5:0] WCOUNT_OFS = 6'h01;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } opb_state_e;

  // OPB bit i lands on user bit 31-i; enable k covers OPB byte k.
  function automatic logic [31:0] be_merge(
    input logic [31:0] old_val,
    input logic [0:31] opb_data,
    input logic [0:3]  opb_be
  );
    logic [31:0] merged;
    merged = old_val;
    for (int k = 0; k < 4; k++) begin
      if (opb_be[k]) begin
        for (int b = 0; b < 8; b++) begin
          merged[31 - 8*k - b] = opb_data[8*k + b];
        end
      end
    end
    return merged;
  endfunction

  function automatic logic [0:31] to_opb(input logic [31:0] user_val);
    logic [0:31] bus;
    for (int i = 0; i < 32; i++) begin
      bus[i] = user_val[31 - i];
    end
    return bus;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opb_register_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_ppc2simulink
// Purpose  : PPC-writable 32-bit control register on OPB, driven into fabric
//            with update strobe, readback and a write counter.
// Revision : 1.0
// ============================================================================
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [0:31] C_BASEADDR    = 32'h01000800,
  parameter logic [0:31] C_HIGHADDR    = 32'h010008FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter              C_FAMILY      = "virtex5",
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  opb_state_e  r_state;
  opb_state_e  w_next_state;
  logic [31:0] r_data;
  logic [31:0] r_wcount;
  logic [0:31] r_dbus;
  logic        r_valid;

  logic        w_hit;
  logic        w_sample;
  logic [5:0]  w_ofs;
  logic        w_unused;

  assign w_hit    = OPB_select && (OPB_ABus[0:23] == C_BASEADDR[0:23]);
  assign w_ofs    = OPB_ABus[24:29];
  // Hits arriving while ACK is presented are deliberately dropped.
  assign w_sample = (r_state == IDLE) && w_hit;

  // Burst hint, byte lane bits and informational parameters carry no function.
  assign w_unused = &{1'b0, OPB_seqAddr, OPB_ABus[30:31], C_HIGHADDR[31],
                      C_OPB_AWIDTH[0], C_OPB_DWIDTH[0], C_FAMILY[0]};

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_data   <= C_RESET_VALUE;
      r_wcount <= 32'h0;
      r_dbus   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_dbus  <= '0;
      r_valid <= 1'b0;
      if (w_sample) begin
        if (OPB_RNW) begin
          if (w_ofs == DATA_OFS) begin
            r_dbus <= to_opb(r_data);
          end else if (w_ofs == WCOUNT_OFS) begin
            r_dbus <= to_opb(r_wcount);
          end
        end else if ((w_ofs == DATA_OFS) && (OPB_BE != 4'b0000)) begin
          // Strobe fires even when the merged value is unchanged.
          r_data   <= be_merge(r_data, OPB_DBus, OPB_BE);
          r_valid  <= 1'b1;
          r_wcount <= r_wcount + 32'h1;
        end
      end
    end
  end

  assign Sl_xferAck      = (r_state == ACK);
  assign Sl_DBus         = r_dbus;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = r_data;
  assign user_data_valid = r_valid;

endmodule
`default_nettype wire
